// File: rtl/anima_pkg.sv
// Shared types and geometry helpers for the defeat-screen sprite animator.
package anima_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DESCEND = 2'd1,
    BOUNCE  = 2'd2
  } state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  function automatic int sprite_w(input int scale);
    return 8 * scale;
  endfunction

  function automatic int x_max(input int h_active, input int scale);
    return h_active - sprite_w(scale);
  endfunction

  // Rightmost legal left column for the default geometry (640 wide, 16 px sprite)
  localparam int X_MAX = x_max(640, 2);

endpackage

// File: rtl/detector_quadro.sv
// One-clk frame tick at the first blanking line, tolerant of counters held for several clks.
module detector_quadro #(
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  output logic       quadro
);

  logic cond, cond_d;

  assign cond = (h_counter == 10'd0) && (v_counter == 10'(V_ACTIVE));

  // cond_d comes out of reset high so a condition already present at release is not a new edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cond_d <= 1'b1;
      quadro <= 1'b0;
    end else begin
      cond_d <= cond;
      quadro <= cond & ~cond_d;
    end
  end

endmodule

// File: rtl/anima_derrota.sv
// Defeat-screen sprite motion: descend to a target row, then bounce between the side walls.
module anima_derrota
  import anima_pkg::*;
#(
  parameter int SCALE       = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int STEP        = 2,
  parameter int ANIM_FRAMES = 15,
  parameter int START_X     = 312,
  parameter int START_Y     = 0,
  parameter int TARGET_Y    = 232
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  output logic [9:0] pos_X,
  output logic [9:0] pos_Y,
  output logic       troca,
  output logic       em_posicao,
  output logic       quadro
);

  localparam int XM  = x_max(H_ACTIVE, SCALE);
  localparam int ACW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  state_t         state, state_nx;
  dir_t           dir, dir_nx;
  logic [9:0]     px_nx, py_nx;
  logic           troca_nx, em_nx, clear;
  logic [ACW-1:0] acnt, acnt_nx;
  logic [10:0]    sum_x, sum_y;
  logic           tick;

  detector_quadro #(.V_ACTIVE(V_ACTIVE)) u_det (
    .clk       (clk),
    .reset     (reset),
    .h_counter (h_counter),
    .v_counter (v_counter),
    .quadro    (tick)
  );

  assign quadro = tick;

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    px_nx    = pos_X;
    py_nx    = pos_Y;
    troca_nx = troca;
    em_nx    = em_posicao;
    acnt_nx  = acnt;
    clear    = 1'b0;
    sum_x    = {1'b0, pos_X} + 11'(STEP);
    sum_y    = {1'b0, pos_Y} + 11'(STEP);
    case (state)
      IDLE: if (enable) state_nx = DESCEND;
      DESCEND, BOUNCE: begin
        // dropping enable wins over a coinciding tick
        if (!enable) clear = 1'b1;
        else if (tick) begin
          if (acnt == ACW'(ANIM_FRAMES - 1)) begin
            acnt_nx  = '0;
            troca_nx = ~troca;
          end else begin
            acnt_nx = acnt + 1'b1;
          end
          if (state == DESCEND) begin
            if (sum_y >= 11'(TARGET_Y)) begin
              py_nx    = 10'(TARGET_Y);
              state_nx = BOUNCE;
              em_nx    = 1'b1;
            end else begin
              py_nx = sum_y[9:0];
            end
          end else if (dir == DIR_RIGHT) begin
            if (sum_x >= 11'(XM)) begin
              px_nx  = 10'(XM);
              dir_nx = DIR_LEFT;
            end else begin
              px_nx = sum_x[9:0];
            end
          end else begin
            if ({1'b0, pos_X} <= 11'(STEP)) begin
              px_nx  = '0;
              dir_nx = DIR_RIGHT;
            end else begin
              px_nx = pos_X - 10'(STEP);
            end
          end
        end
      end
      default: clear = 1'b1;
    endcase
    if (clear) begin
      state_nx = IDLE;
      dir_nx   = DIR_RIGHT;
      px_nx    = 10'(START_X);
      py_nx    = 10'(START_Y);
      troca_nx = 1'b0;
      em_nx    = 1'b0;
      acnt_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dir        <= DIR_RIGHT;
      pos_X      <= 10'(START_X);
      pos_Y      <= 10'(START_Y);
      troca      <= 1'b0;
      em_posicao <= 1'b0;
      acnt       <= '0;
    end else begin
      state      <= state_nx;
      dir        <= dir_nx;
      pos_X      <= px_nx;
      pos_Y      <= py_nx;
      troca      <= troca_nx;
      em_posicao <= em_nx;
      acnt       <= acnt_nx;
    end
  end

endmodule

// File: tb/tb_anima_derrota.sv
// Directed/randomized bench for anima_derrota against an integer reference of the motion rules.
module tb_anima_derrota;

  localparam int SP = 2, XMX = 624, TGT = 232, AF = 15, SX = 312, SY = 0, VA = 480;

  logic       clk = 1'b0, reset, enable;
  logic [9:0] h_counter, v_counter, pos_X, pos_Y;
  logic       troca, em_posicao, quadro;

  int checks = 0, passes = 0;
  int mx, my, mright, mtroca, macnt, mmode;  // mmode: 0 idle, 1 descend, 2 bounce
  int pulses;

  always #5 clk = ~clk;

  anima_derrota dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .h_counter  (h_counter),
    .v_counter  (v_counter),
    .pos_X      (pos_X),
    .pos_Y      (pos_Y),
    .troca      (troca),
    .em_posicao (em_posicao),
    .quadro     (quadro)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    mx = SX; my = SY; mright = 1; mtroca = 0; macnt = 0; mmode = 0;
  endtask

  task automatic model_tick();
    if (mmode == 0) return;
    macnt++;
    if (macnt == AF) begin macnt = 0; mtroca = 1 - mtroca; end
    if (mmode == 1) begin
      my = (my + SP > TGT) ? TGT : my + SP;
      if (my == TGT) mmode = 2;
    end else if (mright == 1) begin
      if (mx + SP >= XMX) begin mx = XMX; mright = 0; end
      else mx = mx + SP;
    end else begin
      if (mx <= SP) begin mx = 0; mright = 1; end
      else mx = mx - SP;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pos_X"}, 32'(pos_X), 32'(mx));
    check({tag, ".pos_Y"}, 32'(pos_Y), 32'(my));
    check({tag, ".troca"}, 32'(troca), 32'(mtroca));
    check({tag, ".em_posicao"}, 32'(em_posicao), (mmode == 2) ? 32'd1 : 32'd0);
  endtask

  // One video frame: tick condition held for `hold` clks, optionally dropping enable during the pulse
  task automatic frame(input int hold, input bit drop);
    pulses = 0;
    @(negedge clk);
    h_counter = 10'd0; v_counter = 10'(VA);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (quadro) pulses++;
      if (drop && i == 0) begin @(negedge clk); enable = 1'b0; end
    end
    @(negedge clk);
    h_counter = 10'($urandom_range(1, 639)); v_counter = 10'($urandom_range(0, 479));
    repeat (3) begin @(posedge clk); #1; if (quadro) pulses++; end
    check("quadro_once", 32'(pulses), 32'd1);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; h_counter = 10'd0; v_counter = 10'(VA);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.quadro", 32'(quadro), 32'd0);

    // condition already high when reset releases: no pulse
    @(negedge clk); reset = 1'b1;
    pulses = 0;
    repeat (4) begin @(posedge clk); #1; if (quadro) pulses++; end
    check("no_pulse_at_release", 32'(pulses), 32'd0);
    @(negedge clk); h_counter = 10'd7; v_counter = 10'd100;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 3; i++) begin
      frame($urandom_range(1, 3), 1'b0);
      check_all("idle");
    end

    @(negedge clk); enable = 1'b1; mmode = 1;
    repeat (2) @(posedge clk);
    for (int t = 1; t <= 590; t++) begin
      frame($urandom_range(1, 3), 1'b0);
      model_tick();
      check_all("run");
      case (t)
        10:  begin check("t10.pos_Y", 32'(pos_Y), 32'd20); check("t10.pos_X", 32'(pos_X), 32'd312); end
        15:  check("t15.troca", 32'(troca), 32'd1);
        30:  check("t30.troca", 32'(troca), 32'd0);
        115: check("t115.em", 32'(em_posicao), 32'd0);
        116: begin check("t116.pos_Y", 32'(pos_Y), 32'd232); check("t116.em", 32'(em_posicao), 32'd1); end
        271: check("t271.pos_X", 32'(pos_X), 32'd622);
        272: check("t272.pos_X", 32'(pos_X), 32'd624);
        273: check("t273.pos_X", 32'(pos_X), 32'd622);
        583: check("t583.pos_X", 32'(pos_X), 32'd2);
        584: check("t584.pos_X", 32'(pos_X), 32'd0);
        585: check("t585.pos_X", 32'(pos_X), 32'd2);
        default: ;
      endcase
    end

    // enable dropped in the pulse clk: abort wins
    frame(2, 1'b1);
    model_reset();
    check_all("abort");
    frame(1, 1'b0);
    check_all("abort_idle");

    @(negedge clk); enable = 1'b1; mmode = 1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      frame($urandom_range(1, 3), 1'b0);
      model_tick();
      check_all("redescend");
    end
    check("redescend.pos_Y", 32'(pos_Y), 32'd10);

    // asynchronous reset between edges
    @(negedge clk); #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    check("async_reset.quadro", 32'(quadro), 32'd0);
    @(negedge clk); reset = 1'b1; mmode = 1;
    repeat (2) @(posedge clk);
    frame(1, 1'b0);
    model_tick();
    check_all("post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
